// File: rtl/rr_pri_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Also carries the arbiter's FSM state and rotation pointer for observation.
interface rr_pri_arbiter_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  // Handshake: requester i raises req[i] and keeps it high until it sees
  // gnt_valid with gnt_idx == i. It then holds req[i] while using the
  // resource and pulses ack for one cycle to release it. Dropping req[i]
  // without ack abandons the grant. A grant always ends with one idle cycle.
  logic [N-1:0] req;
  logic         mode;
  logic         ack;
  logic         any_req;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;
  logic [0:0]   dbg_state;
  logic [W-1:0] dbg_ptr;

  modport master (
    output req, mode, ack,
    input  any_req, gnt_valid, gnt_idx, gnt_onehot, dbg_state, dbg_ptr
  );

  modport slave (
    input  req, mode, ack,
    output any_req, gnt_valid, gnt_idx, gnt_onehot, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/rr_pri_arbiter.sv
// Two-state arbiter: fixed priority (highest index wins) or descending
// round-robin from a rotation pointer; a grant is held until ack or abort.
module rr_pri_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  rr_pri_arbiter_if.slave     bus
);
  localparam logic [0:0]   ST_IDLE  = 1'b0;
  localparam logic [0:0]   ST_GRANT = 1'b1;
  localparam logic [W-1:0] PTR_MAX  = W'(N - 1);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]   state_q;
  logic         gnt_valid_q;
  logic [W-1:0] gnt_idx_q;
  logic [N-1:0] gnt_onehot_q;
  logic [W-1:0] ptr_q;
  logic         grant_rr_q;

  logic [W-1:0] hi_all;
  logic [W-1:0] hi_low;
  logic         any_low;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_onehot;
  logic         held_req;
  logic         release_grant;

  // Searching ptr, ptr-1, ..., 0 then N-1, ..., ptr+1 is the same as taking
  // the highest request at or below ptr, else the highest request overall.
  always_comb begin
    hi_all  = '0;
    hi_low  = '0;
    any_low = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i]) begin
        hi_all = W'(i);
        if (W'(i) <= ptr_q) begin
          hi_low  = W'(i);
          any_low = 1'b1;
        end
      end
    end
    win_idx = (bus.mode && any_low) ? hi_low : hi_all;
  end

  assign win_onehot    = ONE_HOT0 << win_idx;
  assign held_req      = |(bus.req & gnt_onehot_q);
  assign release_grant = bus.ack || !held_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      ptr_q        <= PTR_MAX;
      grant_rr_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|bus.req) begin
            state_q      <= ST_GRANT;
            gnt_valid_q  <= 1'b1;
            gnt_idx_q    <= win_idx;
            gnt_onehot_q <= win_onehot;
            grant_rr_q   <= bus.mode;
          end
        end
        ST_GRANT: begin
          if (release_grant) begin
            state_q      <= ST_IDLE;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            // Only a completed round-robin grant rotates the pointer; the
            // mode captured at the decision governs, not the live input.
            if (bus.ack && grant_rr_q) begin
              ptr_q <= (gnt_idx_q == '0) ? PTR_MAX : gnt_idx_q - 1'b1;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          gnt_valid_q  <= 1'b0;
          gnt_idx_q    <= '0;
          gnt_onehot_q <= '0;
        end
      endcase
    end
  end

  assign bus.any_req    = |bus.req;
  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_idx    = gnt_idx_q;
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_ptr    = ptr_q;
endmodule

// File: tb/tb_rr_pri_arbiter.sv
// Directed bench for rr_pri_arbiter with N=4; expectations are hand-computed.
module tb_rr_pri_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_pri_arbiter_if #(.N(N), .W(W)) bus ();

  rr_pri_arbiter #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic gv, input int idx);
    logic [31:0] exp_oh;
    logic [31:0] exp_idx;
    exp_oh  = gv ? (32'd1 << idx) : 32'd0;
    exp_idx = gv ? 32'(idx) : 32'd0;
    check({tag, ".gnt_valid"},  32'(bus.gnt_valid),  32'(gv));
    check({tag, ".gnt_idx"},    32'(bus.gnt_idx),    exp_idx);
    check({tag, ".gnt_onehot"}, 32'(bus.gnt_onehot), exp_oh);
    check({tag, ".state"},      32'(bus.dbg_state),  32'(gv));
  endtask

  task automatic check_ptr(input string tag, input int p);
    check({tag, ".ptr"}, 32'(bus.dbg_ptr), 32'(p));
  endtask

  int rr_seq[5] = '{3, 2, 1, 0, 3};

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.req  = '0;
    bus.mode = 1'b0;
    bus.ack  = 1'b0;
    step();
    step();
    check_grant("reset", 1'b0, 0);
    check_ptr("reset", 3);
    bus.req = 4'b0101;
    #1;
    check("reset.any_req_follows", 32'(bus.any_req), 32'd1);
    bus.req = '0;
    rst = 1'b0;
    step();
    check_grant("idle_no_req", 1'b0, 0);

    // fixed priority, held grant, re-grant after one idle cycle
    bus.mode = 1'b0;
    bus.req  = 4'b0110;
    step();
    check_grant("fixed.first", 1'b1, 2);
    step();
    check_grant("fixed.hold", 1'b1, 2);
    bus.ack = 1'b1;
    step();
    check_grant("fixed.ack_idle", 1'b0, 0);
    check_ptr("fixed.ack_idle", 3);
    bus.ack = 1'b0;
    step();
    check_grant("fixed.regrant", 1'b1, 2);
    bus.ack = 1'b1;
    step();
    check_grant("fixed.ack2", 1'b0, 0);
    check_ptr("fixed.ack2", 3);

    // round-robin rotation with all requesters active
    bus.mode = 1'b1;
    bus.req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      bus.ack = 1'b0;
      step();
      check_grant($sformatf("rr.grant%0d", k), 1'b1, rr_seq[k]);
      bus.ack = 1'b1;
      step();
      check_grant($sformatf("rr.gap%0d", k), 1'b0, 0);
    end
    check_ptr("rr.end", 2);

    // ack together with request drop counts as ack
    bus.ack = 1'b0;
    bus.req = 4'b0100;
    step();
    check_grant("simul.grant", 1'b1, 2);
    bus.ack = 1'b1;
    bus.req = 4'b0000;
    step();
    check_grant("simul.idle", 1'b0, 0);
    check_ptr("simul.idle", 1);
    bus.ack = 1'b0;
    bus.req = 4'b1111;
    step();
    check_grant("simul.next", 1'b1, 1);
    bus.ack = 1'b1;
    step();
    check_ptr("simul.after", 0);

    // reset during a grant
    bus.ack = 1'b0;
    step();
    check_grant("rst.grant", 1'b1, 0);
    rst = 1'b1;
    step();
    check_grant("rst.mid", 1'b0, 0);
    check_ptr("rst.mid", 3);
    rst = 1'b0;
    bus.req = 4'b0000;
    #1;
    check("rst.any_req0", 32'(bus.any_req), 32'd0);
    step();
    check_grant("rst.no_req", 1'b0, 0);
    bus.req = 4'b0001;
    #1;
    check("rst.any_req1", 32'(bus.any_req), 32'd1);
    check_grant("rst.not_yet", 1'b0, 0);
    step();
    check_grant("rst.req0", 1'b1, 0);
    bus.ack = 1'b1;
    step();
    check_ptr("rst.ack0", 3);

    // abort leaves the pointer alone
    bus.ack = 1'b0;
    bus.req = 4'b0010;
    step();
    check_grant("abort.grant", 1'b1, 1);
    bus.req = 4'b0000;
    step();
    check_grant("abort.idle", 1'b0, 0);
    check_ptr("abort.idle", 3);
    bus.req = 4'b1010;
    step();
    check_grant("abort.next", 1'b1, 3);
    bus.ack = 1'b1;
    step();
    check_ptr("abort.ack", 2);

    // ack in idle is ignored
    bus.req = 4'b0000;
    step();
    check_grant("idle_ack", 1'b0, 0);
    check_ptr("idle_ack", 2);

    // mode change and other-bit changes during a grant
    bus.ack  = 1'b0;
    bus.mode = 1'b0;
    bus.req  = 4'b0011;
    step();
    check_grant("mode.grant", 1'b1, 1);
    bus.mode = 1'b1;
    bus.req  = 4'b1011;
    step();
    check_grant("mode.hold", 1'b1, 1);
    bus.ack = 1'b1;
    step();
    check_grant("mode.ack", 1'b0, 0);
    check_ptr("mode.ack", 2);
    bus.ack = 1'b0;
    bus.req = 4'b1001;
    step();
    check_grant("mode.rr_next", 1'b1, 0);
    bus.ack = 1'b1;
    step();
    check_ptr("mode.rr_ack", 3);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_pri_arbiter.md
RR_PRI_ARBITER -- requirements
Module: rr_pri_arbiter

Interface
REQ-001 Parameter N, default 8, number of request lines; legal range 2..64, non-power-of-2 allowed.
REQ-002 Parameter W, default $clog2(N), width of the grant index; not overridden by users.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  N  request vector; bit i set = requester i wants the resource.
REQ-006 mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 ack  input  1  downstream completion; releases the current grant.
REQ-008 any_req  output  1  combinational OR of all req bits, independent of state and reset.
REQ-009 gnt_valid  output  1  registered; a grant is held.
REQ-010 gnt_idx  output  W  registered binary index of the granted requester.
REQ-011 gnt_onehot  output  N  registered one-hot grant; equals 1<<gnt_idx when gnt_valid=1, else all zero.

Function
REQ-012 The FSM SHALL have two states: IDLE and GRANT.
REQ-013 In IDLE with req nonzero, the winner is computed from req, mode and ptr; next cycle: state=GRANT, gnt_valid=1, gnt_idx/gnt_onehot = winner; latency 1 clock from req to grant.
REQ-014 In IDLE with req zero, the block SHALL stay in IDLE with all grant outputs zero.
REQ-015 Fixed mode: winner = highest set index of req; ptr is ignored and never updated.
REQ-016 Round-robin mode: search order ptr, ptr-1, ..., 0, N-1, ..., ptr+1 (descending, wrap mod N); first set bit wins.
REQ-017 ptr is W bits wide, holds values 0..N-1 only, and updates only on an acked grant in round-robin mode: ptr <= (gnt_idx==0) ? N-1 : gnt_idx-1.
REQ-018 mode is sampled only at the IDLE->GRANT decision; mode changes during GRANT do not affect the held grant.
REQ-019 In GRANT, the outputs SHALL hold stable until ack=1 or req[gnt_idx]=0.
REQ-020 In GRANT with ack=1, the next cycle returns to IDLE with grant outputs zero, and ptr updates per REQ-017.
REQ-021 In GRANT with ack=0 and req[gnt_idx]=0 (abort), the next cycle returns to IDLE with grant outputs zero, and ptr is not updated.
REQ-022 ack and the drop of req[gnt_idx] in the same cycle SHALL be treated as ack (ptr updates).
REQ-023 ack while in IDLE SHALL be ignored.
REQ-024 Every grant is followed by at least one IDLE cycle; back-to-back grants are separated by exactly one cycle of gnt_valid=0.
REQ-025 Changes to req bits other than gnt_idx during GRANT SHALL have no effect until the next IDLE decision.

Reset
REQ-026 While rst=1 at a clock edge: state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, ptr=N-1; rst takes priority over all other inputs.
REQ-027 Reset asserted during GRANT SHALL drop the grant on the following edge without a ptr update; the first decision after reset in round-robin mode equals the fixed-priority result.
REQ-028 any_req SHALL follow req during reset.

Verification (N=4)
REQ-029 Fixed mode: req=0110, hold, ack one cycle after gnt_valid -> gnt_idx=2, gnt_onehot=0100; after ack, IDLE, then gnt_idx=2 again.
REQ-030 Round-robin: req=1111 constant, ack each grant -> gnt_idx sequence 3,2,1,0,3, with gnt_valid low one cycle between grants.
REQ-031 Abort: grant idx 1 with req=0010, drop req[1] with ack=0 -> gnt_valid=0 next cycle, ptr unchanged (next req=1010 in RR mode yields 3).
REQ-032 Simultaneous ack and req drop on grant idx 2 in RR mode -> IDLE and ptr=1; next req=1111 yields 1.
REQ-033 rst=1 mid-GRANT -> all outputs zero next edge, ptr=3; req=0000 -> any_req=0, gnt_valid stays 0; req=0001 -> any_req=1 immediately, gnt_idx=0 one cycle later.
REQ-034 Mode toggled 0->1 during GRANT -> held grant unchanged; the new mode applies at the next IDLE decision.
